// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register of the five-stage MIPS
// core (addi, R-type, lw, sw, beq).
//
// Contents:
//   - default parameter values for data, register-address and counter widths
//   - primary opcode constants
//   - ALUOp class encodings driven by the main decoder
//   - ctrl_t: the 9-bit control bundle carried from ID into EX
//   - BUBBLE: the all-zero control bundle (no write, no memory, no branch)
//   - pack_ctrl: builds a ctrl_t from the individual decoder bits
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Default widths.
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    // Primary opcodes, instr[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // ALU operation classes produced by the main decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bundle. Field order is fixed so the bundle can be compared
    // and zeroed as a single 9-bit vector.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble changes no architectural state: every control bit is zero.
    localparam ctrl_t BUBBLE = 9'b0_0000_0000;

    // Collect the individual decoder outputs into one bundle.
    function automatic ctrl_t pack_ctrl(
        input logic       reg_dst,
        input logic       alu_src,
        input logic       reg_write,
        input logic       mem_write,
        input logic       mem_read,
        input logic       mem_to_reg,
        input logic       branch,
        input logic [1:0] alu_op
    );
        ctrl_t c;
        c.reg_dst    = reg_dst;
        c.alu_src    = alu_src;
        c.reg_write  = reg_write;
        c.mem_write  = mem_write;
        c.mem_read   = mem_read;
        c.mem_to_reg = mem_to_reg;
        c.branch     = branch;
        c.alu_op     = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare. A load sitting in EX whose
// destination (rt) matches either source field of the instruction in ID
// cannot forward in time, so ID must wait one cycle.
//
// Ports:
//   ex_mem_read  in   1       EX holds a load
//   ex_rt        in   REG_AW  destination register of the load in EX
//   id_rs        in   REG_AW  rs field of the ID instruction
//   id_rt        in   REG_AW  rt field of the ID instruction
//   hazard       out  1       load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              hazard
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic dest_real_s;
    logic rs_match_s;
    logic rt_match_s;

    // Compare the load destination against both ID source fields.
    // rt is compared whatever the ID opcode is; for addi/lw that field is a
    // destination and the resulting stall is harmless. $zero never stalls
    // because writes to it are discarded.
    always_comb begin
        dest_real_s = (ex_rt != REG_ZERO);
        rs_match_s  = (ex_rt == id_rs);
        rt_match_s  = (ex_rt == id_rt);
        if (ex_mem_read && dest_real_s && (rs_match_s || rt_match_s)) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall, branch-flush squash and a
// saturating stall-cycle counter.
//
// Ports:
//   clk_i                       in   1       clock, rising edge
//   rst_i                       in   1       async active-high reset
//   flush_i                     in   1       taken branch: squash ID instruction
//   RegDst_i .. Branch_i        in   1 each  decoder control bits
//   ALUOp_i                     in   2       decoder ALU op class
//   pc4_i                       in   DATA_W  PC+4 of the ID instruction
//   rs_data_i, rt_data_i        in   DATA_W  register-file read data
//   imm_i                       in   DATA_W  sign-extended immediate
//   rs_i, rt_i, rd_i            in   REG_AW  ID register fields
//   funct_i                     in   6       instr[5:0]
//   *_o (same names)            out          registered EX copies of the above
//   ex_valid_o                  out  1       EX holds a real instruction
//   stall_o                     out  1       combinational: hold PC and IF/ID
//   stall_cnt_o                 out  CNT_W   saturating hazard-bubble count
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,

    input  logic              RegDst_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic              MemtoReg_i,
    input  logic              Branch_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [5:0]        funct_i,

    output logic              RegDst_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic              MemtoReg_o,
    output logic              Branch_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [5:0]        funct_o,

    output logic              ex_valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};

    // Control bundle presented by ID and the one held in EX.
    ctrl_t             id_ctrl_s;
    ctrl_t             ex_ctrl_r;
    ctrl_t             ex_ctrl_nxt_s;

    logic              ex_valid_r;
    logic              ex_valid_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_nxt_s;

    // Data path registers; they load every cycle, bubble or not.
    logic [DATA_W-1:0] pc4_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] rd_r;
    logic [5:0]        funct_r;

    logic              hazard_s;
    logic              bubble_s;
    logic              count_s;

    // Load-use compare between the load in EX and the ID source fields.
    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_mem_read (ex_ctrl_r.mem_read),
        .ex_rt       (rt_r),
        .id_rs       (rs_i),
        .id_rt       (rt_i),
        .hazard      (hazard_s)
    );

    // Bundle the individual decoder bits presented by ID.
    always_comb begin
        id_ctrl_s = pack_ctrl(RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i,
                              MemRead_i, MemtoReg_i, Branch_i, ALUOp_i);
    end

    // Next EX contents: a flush or a hazard both turn the slot into a bubble.
    // Only hazard bubbles are counted, and a flush overrides the hazard so a
    // squashed consumer neither stalls the front end nor bumps the counter.
    always_comb begin
        bubble_s = flush_i | hazard_s;
        count_s  = hazard_s & ~flush_i;
        if (bubble_s) begin
            ex_ctrl_nxt_s  = BUBBLE;
            ex_valid_nxt_s = 1'b0;
        end else begin
            ex_ctrl_nxt_s  = id_ctrl_s;
            ex_valid_nxt_s = 1'b1;
        end
        if (count_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
    end

    // Pipeline register with asynchronous clear to the bubble state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_ctrl_r   <= BUBBLE;
            ex_valid_r  <= 1'b0;
            stall_cnt_r <= CNT_ZERO;
            pc4_r       <= DATA_ZERO;
            rs_data_r   <= DATA_ZERO;
            rt_data_r   <= DATA_ZERO;
            imm_r       <= DATA_ZERO;
            rs_r        <= REG_ZERO;
            rt_r        <= REG_ZERO;
            rd_r        <= REG_ZERO;
            funct_r     <= 6'b00_0000;
        end else begin
            ex_ctrl_r   <= ex_ctrl_nxt_s;
            ex_valid_r  <= ex_valid_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
            pc4_r       <= pc4_i;
            rs_data_r   <= rs_data_i;
            rt_data_r   <= rt_data_i;
            imm_r       <= imm_i;
            rs_r        <= rs_i;
            rt_r        <= rt_i;
            rd_r        <= rd_i;
            funct_r     <= funct_i;
        end
    end

    // EX-stage outputs straight from the registers.
    always_comb begin
        RegDst_o    = ex_ctrl_r.reg_dst;
        ALUSrc_o    = ex_ctrl_r.alu_src;
        RegWrite_o  = ex_ctrl_r.reg_write;
        MemWrite_o  = ex_ctrl_r.mem_write;
        MemRead_o   = ex_ctrl_r.mem_read;
        MemtoReg_o  = ex_ctrl_r.mem_to_reg;
        Branch_o    = ex_ctrl_r.branch;
        ALUOp_o     = ex_ctrl_r.alu_op;
        pc4_o       = pc4_r;
        rs_data_o   = rs_data_r;
        rt_data_o   = rt_data_r;
        imm_o       = imm_r;
        rs_o        = rs_r;
        rt_o        = rt_r;
        rd_o        = rd_r;
        funct_o     = funct_r;
        ex_valid_o  = ex_valid_r;
        stall_cnt_o = stall_cnt_r;
    end

    // The front-end hold must act in the same cycle the hazard is seen, so
    // it is the one output that is not registered.
    always_comb begin
        stall_o = count_s;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage MIPS core (addi, R-type, lw, sw, beq).
- Registers the main decoder's control bundle and the ID-stage operands into the EX stage.
- Contains load-use hazard detection: requests an IF/ID stall and inserts a bubble.
- Squashes the ID-stage instruction on a taken-branch flush, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  taken branch; squash the ID instruction.
- RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i, Branch_i  in  1 each  decoder control bits.
- ALUOp_i  in  2  decoder ALU op class.
- pc4_i  in  DATA_W  PC+4 of the ID instruction.
- rs_data_i, rt_data_i  in  DATA_W  register-file read data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs_i, rt_i, rd_i  in  REG_AW  ID register fields.
- funct_i  in  6  instr[5:0].
- *_o (same names)  out  same widths  registered EX-stage copies of every input above except flush_i.
- ex_valid_o  out  1  EX holds a real instruction, not a bubble.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- stall_cnt_o  out  CNT_W  hazard-bubble cycle count.

Behaviour:
- Reset: while rst_i is high, all *_o, ex_valid_o and stall_cnt_o are 0 immediately, without waiting for a clock edge. An all-zero register is a bubble (RegWrite=MemWrite=MemRead=Branch=0).
- Hazard equation:
  - hazard = MemRead_o & (rt_o != 0) & ((rt_o == rs_i) | (rt_o == rt_i)).
  - rt_i is compared regardless of opcode; the conservative stall on addi/lw is accepted.
- stall_o = hazard & ~flush_i. It is purely combinational from the registered state and the ID inputs, and has no clock latency.
- Per rising edge, priority order:
  - 1) flush_i=1: load a bubble. All seven control bits and ALUOp_o become 0, ex_valid_o=0. Data/address/funct/pc fields still capture their inputs (don't-care).
  - 2) else hazard=1: load a bubble as above; stall_cnt_o increments.
  - 3) else: capture all inputs; ex_valid_o=1.
- The instruction stalled in ID re-presents next cycle and the hazard clears, since EX then holds a bubble. One lw produces exactly one bubble.
- stall_cnt_o saturates at all-ones and never wraps. Flush cycles are not counted.
- Latency: one cycle from ID inputs to *_o.
- Reset mid-stall: stall_o drops immediately because MemRead_o is 0. Counter clears.
- Simultaneous flush and hazard: flush wins, stall_o=0, no count.
- rt_o == 0 never stalls: $zero is not a real destination.
- Back-to-back lw to the same register: each consumer stalls independently, one bubble per lw.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=000000, OP_ADDI=001000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100;
  - ALUOp encodings: 00 add, 01 sub, 10 funct;
  - the control-bundle struct (9 bits) and its all-zero BUBBLE constant.
- One natural sub-module: hazard_detect (combinational load-use compare producing hazard). The register and counter stay in id_ex_stage.

Test Plan:
- Reset: assert rst_i mid-cycle with non-zero inputs -> all outputs 0 before the next edge; ex_valid_o=0, stall_cnt_o=0.
- Plain capture: addi $8,$9,5 (RegWrite=1, ALUSrc=1, ALUOp=00, imm_i=5, rs_i=9, rt_i=8), no hazard -> next edge RegWrite_o=1, ALUSrc_o=1, imm_o=5, rt_o=8, ex_valid_o=1, stall_o=0.
- Load-use:
  - Sequence: lw $8,0($9) into EX, then ID presents add $10,$8,$11 (rs_i=8).
  - Required: stall_o=1 combinationally; next edge EX control is all 0, ex_valid_o=0, stall_cnt_o=1.
  - Following edge: the add is captured and stall_o=0.
- No stall on $zero / unrelated registers: lw $0 in EX with rs_i=0 -> stall_o=0. lw $8 with rs_i=3, rt_i=4 -> stall_o=0.
- Flush priority: lw $8 in EX, ID rs_i=8, flush_i=1 -> stall_o=0; next edge bubble; stall_cnt_o unchanged.
- Saturation: preload with CNT_W=4 and force 20 hazard cycles -> stall_cnt_o holds 15; no wrap to 0.
